// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    localparam logic [3:0] RD_BE = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port between
// an instruction requester (read only) and a data requester (read/write).
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byte_enable,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        err
);

    arb_state_e  state_q, state_d;
    gnt_e        last_gnt_q, last_gnt_d;
    logic        dropped_q, dropped_d;
    logic        err_q, err_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        i_resp_q, i_resp_d;
    logic        d_resp_q, d_resp_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        i_req;
    logic        d_req;
    logic        pick_d;
    logic        held_req;

    assign i_req    = i_read;
    assign d_req    = d_read | d_write;
    // Data wins unless instruction is also waiting and data had the last grant.
    assign pick_d   = d_req && (!i_req || (last_gnt_q == GNT_I));
    assign held_req = (state_q == BUSY_D) ? d_req : i_req;

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        dropped_d   = dropped_q;
        err_d       = err_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        i_resp_d    = 1'b0;
        d_resp_d    = 1'b0;
        i_rdata_d   = '0;
        d_rdata_d   = '0;

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d     = BUSY_D;
                    last_gnt_d  = GNT_D;
                    dropped_d   = 1'b0;
                    // A simultaneous read+write is resolved as a write.
                    mem_write_d = d_write;
                    mem_read_d  = ~d_write;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_write ? d_wdata : '0;
                    mem_be_d    = d_write ? d_byte_enable : RD_BE;
                    if (d_read && d_write) begin
                        err_d = 1'b1;
                    end
                end else if (i_req) begin
                    state_d     = BUSY_I;
                    last_gnt_d  = GNT_I;
                    dropped_d   = 1'b0;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = RD_BE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (!held_req) begin
                    dropped_d = 1'b1;
                    err_d     = 1'b1;
                end
                if (mem_resp) begin
                    state_d     = RESP;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (!dropped_q && held_req) begin
                        if (state_q == BUSY_D) begin
                            d_resp_d  = 1'b1;
                            d_rdata_d = mem_read_q ? mem_rdata : '0;
                        end else begin
                            i_resp_d  = 1'b1;
                            i_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_gnt_q  <= GNT_I;
            dropped_q   <= 1'b0;
            err_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            dropped_q   <= dropped_d;
            err_q       <= err_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            i_resp_q    <= i_resp_d;
            d_resp_q    <= d_resp_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_be_q;
    assign i_resp          = i_resp_q;
    assign i_rdata         = i_rdata_q;
    assign d_resp          = d_resp_q;
    assign d_rdata         = d_rdata_q;
    assign err             = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: responding memory model, transaction-level reference model and directed scenarios.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_read = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_byte_enable = '0;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mtxn_t;

    logic [31:0] mem_arr [logic [29:0]];
    mtxn_t       mlog[$];
    mtxn_t       m_cur;
    int          mem_delay_fixed = 2;
    bit          m_busy = 0;
    int          m_cnt = 0;
    int          low_cnt = 2;
    bit          prev_strobe = 0;
    bit          strobe;
    logic [31:0] merged;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a[31:2])) return mem_arr[a[31:2]];
        return {a[15:0], ~a[15:0]};
    endfunction

    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; mem_resp = 1'b0; mem_rdata = '0; prev_strobe = 0; low_cnt = 2;
            end else begin
                mem_resp = 1'b0;
                mem_rdata = '0;
                strobe = mem_read | mem_write;
                chk("strobe_excl", {31'd0, mem_read & mem_write}, 32'd0);
                if (m_busy) begin
                    chk("hold_read", {31'd0, mem_read}, {31'd0, ~m_cur.wr});
                    chk("hold_write", {31'd0, mem_write}, {31'd0, m_cur.wr});
                    chk("hold_addr", mem_addr, m_cur.addr);
                    chk("hold_be", {28'd0, mem_byte_enable}, {28'd0, m_cur.be});
                    chk("hold_wdata", mem_wdata, m_cur.wdata);
                end else if (strobe && !prev_strobe) begin
                    chk("strobe_gap", {31'd0, low_cnt >= 2}, 32'd1);
                    m_cur.wr = mem_write; m_cur.addr = mem_addr;
                    m_cur.wdata = mem_wdata; m_cur.be = mem_byte_enable;
                    mlog.push_back(m_cur);
                    m_busy = 1;
                    m_cnt = (mem_delay_fixed < 0) ? int'($urandom_range(0, 4)) : mem_delay_fixed;
                end
                if (m_busy) begin
                    if (m_cnt == 0) begin
                        mem_resp = 1'b1;
                        if (m_cur.wr) begin
                            merged = mem_rd(m_cur.addr);
                            for (int b = 0; b < 4; b++)
                                if (m_cur.be[b]) merged[8*b +: 8] = m_cur.wdata[8*b +: 8];
                            mem_arr[m_cur.addr[31:2]] = merged;
                            mem_rdata = $urandom;
                        end else begin
                            mem_rdata = mem_rd(m_cur.addr);
                        end
                        m_busy = 0;
                    end else begin
                        m_cnt--;
                    end
                end
                low_cnt = strobe ? 0 : ((low_cnt < 100) ? low_cnt + 1 : low_cnt);
                prev_strobe = strobe;
            end
        end
    end

    // ---------------- reference model (transaction level) ----------------
    bit          mt_act = 0;
    bit          mt_side_d = 0;
    bit          mt_wr = 0;
    bit          mt_drop = 0;
    logic [31:0] mt_addr = '0;
    logic [31:0] mt_wdata = '0;
    logic [3:0]  mt_be = '0;
    bit          last_was_d = 0;
    longint      edge_n = 0;
    longint      grant_ok = 0;
    bit          e_iresp = 0, e_dresp = 0, e_err = 0;
    logic [31:0] e_irdata = '0, e_drdata = '0;
    bit          m_ireq, m_dreq, m_held, m_take_d;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mt_act = 0; last_was_d = 0; e_iresp = 0; e_dresp = 0; e_err = 0;
                e_irdata = '0; e_drdata = '0; edge_n = 0; grant_ok = 0;
            end else begin
                m_ireq = i_read;
                m_dreq = d_read | d_write;
                e_iresp = 0; e_dresp = 0; e_irdata = '0; e_drdata = '0;
                if (mt_act) begin
                    m_held = mt_side_d ? m_dreq : m_ireq;
                    if (!m_held) begin mt_drop = 1; e_err = 1; end
                    if (mem_resp) begin
                        mt_act = 0;
                        // one response cycle plus one idle cycle before the next grant
                        grant_ok = edge_n + 2;
                        if (!mt_drop) begin
                            if (mt_side_d) begin e_dresp = 1; e_drdata = mt_wr ? 32'd0 : mem_rdata; end
                            else begin e_iresp = 1; e_irdata = mem_rdata; end
                        end
                    end
                end else if (edge_n >= grant_ok && (m_ireq || m_dreq)) begin
                    m_take_d = m_dreq && !(m_ireq && last_was_d);
                    mt_act = 1; mt_drop = 0; mt_side_d = m_take_d; last_was_d = m_take_d;
                    if (m_take_d) begin
                        mt_wr = d_write; mt_addr = d_addr;
                        mt_wdata = d_write ? d_wdata : 32'd0;
                        mt_be = d_write ? d_byte_enable : 4'hF;
                        if (d_read && d_write) e_err = 1;
                    end else begin
                        mt_wr = 0; mt_addr = i_addr; mt_wdata = 32'd0; mt_be = 4'hF;
                    end
                end
                edge_n++;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("i_resp", {31'd0, i_resp}, {31'd0, e_iresp});
                chk("i_rdata", i_rdata, e_irdata);
                chk("d_resp", {31'd0, d_resp}, {31'd0, e_dresp});
                chk("d_rdata", d_rdata, e_drdata);
                chk("err", {31'd0, err}, {31'd0, e_err});
                chk("mem_read", {31'd0, mem_read}, {31'd0, mt_act && !mt_wr});
                chk("mem_write", {31'd0, mem_write}, {31'd0, mt_act && mt_wr});
                if (mt_act) begin
                    chk("mem_addr", mem_addr, mt_addr);
                    chk("mem_be", {28'd0, mem_byte_enable}, {28'd0, mt_be});
                    if (mt_wr) chk("mem_wdata", mem_wdata, mt_wdata);
                end
            end
        end
    end

    // ---------------- requester tasks ----------------
    task automatic i_access(input logic [31:0] a, output logic [31:0] rd, output int lat);
        bit ok = 0;
        i_addr = a; i_read = 1'b1; rd = '0; lat = 0;
        for (int n = 1; n <= 200 && !ok; n++) begin
            @(negedge clk);
            if (i_resp) begin ok = 1; rd = i_rdata; lat = n; end
        end
        i_read = 1'b0;
        chk("i_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic d_access(input logic rd_f, input logic wr_f, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            output logic [31:0] rd, output int lat);
        bit ok = 0;
        d_addr = a; d_wdata = wd; d_byte_enable = be; d_read = rd_f; d_write = wr_f;
        rd = '0; lat = 0;
        for (int n = 1; n <= 200 && !ok; n++) begin
            @(negedge clk);
            if (d_resp) begin ok = 1; rd = d_rdata; lat = n; end
        end
        d_read = 1'b0; d_write = 1'b0;
        chk("d_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=expired required=finished");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] rd0, rd1, rd2;
    int          l0, l1, l2, pulses;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", {28'd0, mem_byte_enable}, 32'd0);
        chk("rst_resp", {30'd0, i_resp, d_resp}, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single instruction read, 2-cycle memory
        mem_delay_fixed = 2;
        mem_arr[30'h18] = 32'h1234_5678;
        mlog.delete();
        i_access(32'h0000_0060, rd0, l0);
        chk("t1_rdata", rd0, 32'h1234_5678);
        chk("t1_latency", l0, 32'd4);
        chk("t1_count", mlog.size(), 32'd1);
        if (mlog.size() > 0) begin
            chk("t1_addr", mlog[0].addr, 32'h0000_0060);
            chk("t1_kind", {31'd0, mlog[0].wr}, 32'd0);
            chk("t1_be", {28'd0, mlog[0].be}, 32'hF);
        end

        // partial write then read back
        mem_arr[30'h41] = 32'h5555_AAAA;
        mlog.delete();
        d_access(1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011, rd0, l0);
        chk("t2_wr_rdata", rd0, 32'd0);
        d_access(1'b1, 1'b0, 32'h0000_0104, 32'd0, 4'h0, rd1, l1);
        chk("t2_rd_low", {16'd0, rd1[15:0]}, 32'h0000_BEEF);
        chk("t2_rd_full", rd1, 32'h5555_BEEF);
        chk("t2_count", mlog.size(), 32'd2);
        if (mlog.size() == 2) begin
            chk("t2_wr_kind", {31'd0, mlog[0].wr}, 32'd1);
            chk("t2_wr_addr", mlog[0].addr, 32'h0000_0104);
            chk("t2_wr_data", mlog[0].wdata, 32'hDEAD_BEEF);
            chk("t2_wr_be", {28'd0, mlog[0].be}, 32'h3);
            chk("t2_rd_be", {28'd0, mlog[1].be}, 32'hF);
        end

        // tie after reset, then repeated tie
        reset_pulse();
        mem_delay_fixed = 1;
        mlog.delete();
        fork
            begin
                d_access(1'b1, 1'b0, 32'h0000_0300, 32'd0, 4'h0, rd0, l0);
                d_access(1'b1, 1'b0, 32'h0000_0308, 32'd0, 4'h0, rd1, l1);
            end
            i_access(32'h0000_0304, rd2, l2);
        join
        chk("t3_count", mlog.size(), 32'd3);
        if (mlog.size() == 3) begin
            chk("t3_first", mlog[0].addr, 32'h0000_0300);
            chk("t3_second", mlog[1].addr, 32'h0000_0304);
            chk("t3_third", mlog[2].addr, 32'h0000_0308);
        end

        // randomized traffic from both sides
        mem_delay_fixed = -1;
        mlog.delete();
        fork
            for (int k = 0; k < 60; k++) begin
                logic [31:0] r; int l;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                i_access(32'h200 + 32'd4 * $urandom_range(0, 15), r, l);
            end
            for (int k = 0; k < 60; k++) begin
                logic [31:0] r; int l; logic w;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                w = 1'($urandom_range(0, 1));
                d_access(~w, w, 32'h200 + 32'd4 * $urandom_range(0, 15), $urandom, 4'($urandom), r, l);
            end
        join
        chk("rand_count", mlog.size(), 32'd120);

        // asynchronous reset during a data read
        mem_delay_fixed = 10;
        mem_arr[30'h100] = 32'h0BAD_F00D;
        d_addr = 32'h0000_0400; d_read = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 chk("t4_busy", {31'd0, mem_read}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t4_rst_read", {31'd0, mem_read}, 32'd0);
        chk("t4_rst_addr", mem_addr, 32'd0);
        chk("t4_rst_resp", {31'd0, d_resp}, 32'd0);
        chk("t4_rst_err", {31'd0, err}, 32'd0);
        d_read = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_rst_noresp", {31'd0, d_resp}, 32'd0);
        rst_n = 1'b1;
        mem_delay_fixed = 1;
        @(negedge clk);
        d_access(1'b1, 1'b0, 32'h0000_0400, 32'd0, 4'h0, rd0, l0);
        chk("t4_after", rd0, 32'h0BAD_F00D);

        // read and write together
        mlog.delete();
        d_access(1'b1, 1'b1, 32'h0000_0600, 32'hA5A5_5A5A, 4'hF, rd0, l0);
        chk("t5_rdata", rd0, 32'd0);
        chk("t5_err", {31'd0, err}, 32'd1);
        if (mlog.size() > 0) chk("t5_kind", {31'd0, mlog[0].wr}, 32'd1);
        else chk("t5_count", mlog.size(), 32'd1);
        i_access(32'h0000_0604, rd1, l1);
        chk("t5_sticky", {31'd0, err}, 32'd1);
        reset_pulse();
        chk("t5_cleared", {31'd0, err}, 32'd0);

        // instruction request withdrawn mid-transaction
        mem_delay_fixed = 5;
        mlog.delete();
        i_addr = 32'h0000_0500; i_read = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_read = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (i_resp) pulses++;
        end
        chk("t6_noresp", pulses, 32'd0);
        chk("t6_err", {31'd0, err}, 32'd1);
        chk("t6_count", mlog.size(), 32'd1);
        if (mlog.size() > 0) chk("t6_addr", mlog[0].addr, 32'h0000_0500);
        mem_delay_fixed = 1;
        d_access(1'b1, 1'b0, 32'h0000_0104, 32'd0, 4'h0, rd0, l0);
        chk("t6_recover", rd0, 32'h5555_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
